// File: rtl/key_event_classifier.sv
// Classifies each debounced press/release sequence as a short, long or double press.
// Latency: every output is registered and changes in the cycle after the deciding edge.
// No backpressure: the one-cycle pulses are fire-and-forget; busy shows when a sequence is open.
module key_event_classifier #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int CNT_W       = $clog2((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_db,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  // Terminal counts: each timed state leaves at these values, so cnt never wraps.
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             key_q;
  logic             press_edge;
  logic             short_d;
  logic             long_d;
  logic             double_d;
  logic             busy_d;

  // key_q resets to 0 so a key held down through reset is not taken as a new press.
  assign press_edge = key_q & ~key_db;

  // State, timer and key history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      key_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      key_q <= key_db;
    end
  end

  // Next-state and timer logic; release/press always win over the terminal count.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (press_edge) state_next = PRESS1;
      end
      PRESS1: begin
        if (key_db)               state_next = WAIT_GAP;
        else if (cnt == LONG_TC)  state_next = LONG_HOLD;
        else                      cnt_next   = cnt + CNT_ONE;
      end
      LONG_HOLD: begin
        if (key_db) state_next = IDLE;
      end
      WAIT_GAP: begin
        if (!key_db)              state_next = PRESS2;
        else if (cnt == GAP_TC)   state_next = IDLE;
        else                      cnt_next   = cnt + CNT_ONE;
      end
      PRESS2: begin
        if (key_db) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Timer restarts from zero on every state entry.
    if (state_next != state) cnt_next = '0;
  end

  // Output decode: pulses mark the transition that classifies the sequence.
  always_comb begin
    long_d   = (state == PRESS1)   && !key_db && (cnt == LONG_TC);
    double_d = (state == WAIT_GAP) && !key_db;
    short_d  = (state == WAIT_GAP) &&  key_db && (cnt == GAP_TC);
    busy_d   = (state_next != IDLE);
  end

  // Output registers so the application sees glitch-free, edge-aligned pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_pulse  <= short_d;
      long_pulse   <= long_d;
      double_pulse <= double_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_key_event_classifier.sv
// Bench for key_event_classifier with LONG_CYCLES=20, GAP_CYCLES=8.
// A timestamp-based event model predicts the outputs after every edge;
// directed sequences add hand-computed pulse times and counts.
module tb_key_event_classifier;
  localparam int L = 20;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst;
  logic key_db;
  logic short_pulse, long_pulse, double_pulse, busy;

  key_event_classifier #(.LONG_CYCLES(L), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .key_db(key_db),
    .short_pulse(short_pulse), .long_pulse(long_pulse),
    .double_pulse(double_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edge counter: the value read at a rising edge is that edge's id.
  int n = 0;
  always @(posedge clk) n <= n + 1;

  // Model: sequences described by press/release timestamps.
  // mode 0 = no sequence, 1 = first press down, 2 = released awaiting gap,
  // 3 = sequence already classified, waiting for the key to come up.
  int   m_mode = 0;
  int   t_press = 0;
  int   t_rel = 0;
  logic m_prev = 1'b0;
  logic es = 1'b0, el = 1'b0, ed = 1'b0, eb = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_prev = 1'b0;
      es = 1'b0; el = 1'b0; ed = 1'b0; eb = 1'b0;
    end else begin
      es = 1'b0; el = 1'b0; ed = 1'b0;
      case (m_mode)
        0: if (m_prev && !key_db) begin m_mode = 1; t_press = n; end
        1: if (key_db) begin m_mode = 2; t_rel = n; end
           else if (n - t_press == L) begin el = 1'b1; m_mode = 3; end
        2: if (!key_db) begin ed = 1'b1; m_mode = 3; end
           else if (n - t_rel == G) begin es = 1'b1; m_mode = 0; end
        default: if (key_db) m_mode = 0;
      endcase
      eb = (m_mode != 0);
      m_prev = key_db;
    end
  end

  int tests = 0;
  int fails = 0;
  int n_short = 0, n_long = 0, n_double = 0;
  int short_at = -1, long_at = -1, double_at = -1, fall_at = -1;
  logic busy_prev = 1'b0;

  // Per-cycle compare against the model, plus pulse bookkeeping.
  always @(negedge clk) begin
    tests++;
    if ({short_pulse, long_pulse, double_pulse, busy} !== {es, el, ed, eb}) begin
      fails++;
      $display("FAIL model_cmp after edge %0d: dut s/l/d/busy=%b%b%b%b required %b%b%b%b",
               n - 1, short_pulse, long_pulse, double_pulse, busy, es, el, ed, eb);
    end
    if (short_pulse === 1'b1)  begin n_short++;  short_at  = n - 1; end
    if (long_pulse === 1'b1)   begin n_long++;   long_at   = n - 1; end
    if (double_pulse === 1'b1) begin n_double++; double_at = n - 1; end
    if (busy_prev === 1'b1 && busy === 1'b0) fall_at = n - 1;
    busy_prev = busy;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    n_short = 0; n_long = 0; n_double = 0;
    short_at = -1; long_at = -1; double_at = -1; fall_at = -1;
  endtask

  // Drive a level; it is sampled at edges first_edge .. first_edge+cyc-1.
  task automatic hold(input logic v, input int cyc, output int first_edge);
    key_db = v;
    first_edge = n;
    repeat (cyc) begin @(posedge clk); #2; end
  endtask

  initial begin
    int e0, r, e2, x;
    rst = 1'b1;
    key_db = 1'b1;
    #1;
    chk("reset_outputs", {short_pulse, long_pulse, double_pulse, busy}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    hold(1'b1, 3, x);

    // Short press: 5 cycles down, then idle.
    clr();
    hold(1'b0, 5, e0);
    hold(1'b1, 20, r);
    chk("short_release_edge", r, e0 + 5);
    chk("short_count", n_short, 1);
    chk("short_time", short_at, r + 8);
    chk("short_no_other", n_long + n_double, 0);
    chk("short_busy_after", busy, 0);

    // Long press: held 30 cycles.
    clr();
    hold(1'b0, 30, e0);
    hold(1'b1, 12, r);
    chk("long_count", n_long, 1);
    chk("long_time", long_at, e0 + 20);
    chk("long_no_short", n_short + n_double, 0);
    chk("long_busy_fall", fall_at, r);

    // Double press: 5 down, 3 up, 40 down.
    clr();
    hold(1'b0, 5, e0);
    hold(1'b1, 3, r);
    hold(1'b0, 40, e2);
    hold(1'b1, 12, x);
    chk("double_count", n_double, 1);
    chk("double_time", double_at, e2);
    chk("double_no_other", n_short + n_long, 0);
    chk("double_busy_fall", fall_at, x);

    // Boundary: release sampled exactly at press edge + 20.
    clr();
    hold(1'b0, 20, e0);
    hold(1'b1, 15, r);
    chk("bnd_rel_edge", r, e0 + 20);
    chk("bnd_rel_short", n_short, 1);
    chk("bnd_rel_short_time", short_at, r + 8);
    chk("bnd_rel_no_long", n_long + n_double, 0);

    // Boundary: second press sampled exactly at release edge + 8.
    clr();
    hold(1'b0, 5, e0);
    hold(1'b1, 8, r);
    hold(1'b0, 3, e2);
    hold(1'b1, 15, x);
    chk("bnd_gap_edge", e2, r + 8);
    chk("bnd_gap_double", n_double, 1);
    chk("bnd_gap_double_time", double_at, e2);
    chk("bnd_gap_no_short", n_short + n_long, 0);

    // Key held low across reset release: ignored until released once.
    clr();
    key_db = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    hold(1'b0, 50, x);
    chk("held_rst_pulses", n_short + n_long + n_double, 0);
    chk("held_rst_busy", busy, 0);
    hold(1'b1, 3, x);
    hold(1'b0, 5, e0);
    hold(1'b1, 15, r);
    chk("held_rst_then_short", n_short, 1);
    chk("held_rst_short_time", short_at, r + 8);

    // Reset in the middle of the gap wait discards the sequence.
    clr();
    hold(1'b0, 5, e0);
    hold(1'b1, 3, r);
    chk("midgap_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midgap_async_clear", {short_pulse, long_pulse, double_pulse, busy}, 0);
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    hold(1'b1, 20, x);
    chk("midgap_no_pulse", n_short + n_long + n_double, 0);
    chk("midgap_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
